// File: rtl/mul_share_ctrl_pkg.sv
//------------------------------------------------------------------------------
// mul_share_ctrl_pkg : shared state encoding, widths and arbitration helper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mul_share_ctrl_pkg;

  localparam int OPW = 4;
  localparam int PRW = 8;
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_t;

  // On a tie, round-robin favours whichever channel was not served last.
  function automatic chan_t pick_winner(input logic  req_0,
                                        input logic  req_1,
                                        input logic  fixed_prio,
                                        input chan_t last);
    chan_t win;
    win = CH0;
    if (req_0 && req_1) begin
      if (fixed_prio) begin
        win = CH0;
      end else if (last == CH0) begin
        win = CH1;
      end else begin
        win = CH0;
      end
    end else if (req_1) begin
      win = CH1;
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multiplier_4b.sv
//------------------------------------------------------------------------------
// multiplier_4b : combinational unsigned OPW x OPW shift-add array multiplier
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multiplier_4b
  import mul_share_ctrl_pkg::*;
(
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  output logic [PRW-1:0] o_p
);

  logic [PRW-1:0] w_pp  [OPW];
  logic [PRW-1:0] w_sum [OPW+1];

  assign w_sum[0] = '0;

  for (genvar i = 0; i < OPW; i++) begin : g_pp
    assign w_pp[i]    = i_b[i] ? (PRW'(i_a) << i) : '0;
    assign w_sum[i+1] = w_sum[i] + w_pp[i];
  end

  assign o_p = w_sum[OPW];

endmodule

`default_nettype wire

// File: rtl/mul_share_ctrl.sv
//------------------------------------------------------------------------------
// mul_share_ctrl : two-channel arbiter sharing one 4x4 multiplier, 4-phase acks
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_share_ctrl
  import mul_share_ctrl_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [OPW-1:0]  a0,
  input  logic [OPW-1:0]  b0,
  input  logic            req1,
  input  logic [OPW-1:0]  a1,
  input  logic [OPW-1:0]  b1,
  output logic            ack0,
  output logic            ack1,
  output logic [PRW-1:0]  prod,
  output logic            busy,
  output logic [CNTW-1:0] op_cnt
);

  state_t          r_state;
  state_t          w_next;
  chan_t           r_id;
  chan_t           r_last;
  chan_t           w_win;
  logic [OPW-1:0]  r_opa;
  logic [OPW-1:0]  r_opb;
  logic [PRW-1:0]  r_prod;
  logic [CNTW-1:0] r_op_cnt;
  logic [PRW-1:0]  w_mul;
  logic            w_grant;
  logic            w_release;
  logic            w_served_req;

  assign w_win        = pick_winner(req0, req1, FIXED_PRIO, r_last);
  assign w_served_req = (r_id == CH1) ? req1 : req0;

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_release = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_next  = CALC;
          w_grant = 1'b1;
        end
      end
      CALC: begin
        w_next = DONE;
      end
      DONE: begin
        // Hold the ack until the served requester completes its handshake.
        if (!w_served_req) begin
          w_next    = IDLE;
          w_release = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa  <= '0;
      r_opb  <= '0;
      r_id   <= CH0;
      r_last <= CH0;
    end else begin
      if (w_grant) begin
        r_opa <= (w_win == CH1) ? a1 : a0;
        r_opb <= (w_win == CH1) ? b1 : b0;
        r_id  <= w_win;
      end
      if (w_release) begin
        r_last <= r_id;
      end
    end
  end

  multiplier_4b u_mul (
    .i_a (r_opa),
    .i_b (r_opb),
    .o_p (w_mul)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod   <= '0;
      r_op_cnt <= '0;
    end else begin
      if (r_state == CALC) begin
        r_prod <= w_mul;
      end
      if (w_release) begin
        r_op_cnt <= r_op_cnt + 1'b1;
      end
    end
  end

  assign ack0   = (r_state == DONE) && (r_id == CH0);
  assign ack1   = (r_state == DONE) && (r_id == CH1);
  assign busy   = (r_state != IDLE);
  assign prod   = r_prod;
  assign op_cnt = r_op_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_ctrl.sv
//------------------------------------------------------------------------------
// tb_mul_share_ctrl : self-checking bench, round-robin and fixed-priority DUTs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mul_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_0, req0_0, req1_0, ack0_0, ack1_0, busy_0;
  logic [3:0] a0_0, b0_0, a1_0, b1_0;
  logic [7:0] prod_0, cnt_0;
  logic       rst_1, req0_1, req1_1, ack0_1, ack1_1, busy_1;
  logic [3:0] a0_1, b0_1, a1_1, b1_1;
  logic [7:0] prod_1, cnt_1;

  int errors = 0;
  int checks = 0;
  int m_last [2];
  int m_cnt  [2];

  mul_share_ctrl #(.FIXED_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst_0),
    .req0(req0_0), .a0(a0_0), .b0(b0_0),
    .req1(req1_0), .a1(a1_0), .b1(b1_0),
    .ack0(ack0_0), .ack1(ack1_0), .prod(prod_0), .busy(busy_0), .op_cnt(cnt_0)
  );

  mul_share_ctrl #(.FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .rst(rst_1),
    .req0(req0_1), .a0(a0_1), .b0(b0_1),
    .req1(req1_1), .a1(a1_1), .b1(b1_1),
    .ack0(ack0_1), .ack1(ack1_1), .prod(prod_1), .busy(busy_1), .op_cnt(cnt_1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int inst, input int ch, input logic r);
    if (inst == 0) begin
      if (ch == 0) req0_0 = r; else req1_0 = r;
    end else begin
      if (ch == 0) req0_1 = r; else req1_1 = r;
    end
  endtask

  task automatic set_ops(input int inst, input int ch, input logic [3:0] a, input logic [3:0] b);
    if (inst == 0) begin
      if (ch == 0) begin a0_0 = a; b0_0 = b; end else begin a1_0 = a; b1_0 = b; end
    end else begin
      if (ch == 0) begin a0_1 = a; b0_1 = b; end else begin a1_1 = a; b1_1 = b; end
    end
  endtask

  function automatic logic [1:0] get_acks(input int inst);
    return (inst == 0) ? {ack1_0, ack0_0} : {ack1_1, ack0_1};
  endfunction

  function automatic logic [7:0] get_prod(input int inst);
    return (inst == 0) ? prod_0 : prod_1;
  endfunction

  function automatic logic [7:0] get_cnt(input int inst);
    return (inst == 0) ? cnt_0 : cnt_1;
  endfunction

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy_0 : busy_1;
  endfunction

  // Raise the requests in pat (bit0 = ch0, bit1 = ch1), then serve them in the
  // order the arbitration rules dictate, scrambling served operands after grant.
  task automatic serve_pattern(input int inst, input int pat,
                               input logic [3:0] a0v, input logic [3:0] b0v,
                               input logic [3:0] a1v, input logic [3:0] b1v);
    int         order[$];
    int         ch;
    int         n;
    logic [3:0] ea [2];
    logic [3:0] eb [2];
    logic [7:0] exp_p;
    logic [1:0] exp_ack;
    ea[0] = a0v; eb[0] = b0v; ea[1] = a1v; eb[1] = b1v;
    if (pat == 3) begin
      if (inst == 1 || m_last[inst] == 1) order = '{0, 1};
      else order = '{1, 0};
    end else if (pat == 1) begin
      order = '{0};
    end else begin
      order = '{1};
    end
    if ((pat & 1) != 0) begin set_ops(inst, 0, a0v, b0v); set_req(inst, 0, 1'b1); end
    if ((pat & 2) != 0) begin set_ops(inst, 1, a1v, b1v); set_req(inst, 1, 1'b1); end
    foreach (order[k]) begin
      ch = order[k];
      n  = 0;
      while (get_acks(inst) == 2'b00 && n < 12) begin
        tick();
        n++;
        if (get_busy(inst) && get_acks(inst) == 2'b00)
          set_ops(inst, ch, 4'd0, 4'($urandom));
      end
      exp_ack = (ch == 0) ? 2'b01 : 2'b10;
      checks++;
      if (get_acks(inst) !== exp_ack) begin
        errors++;
        $display("FAIL grant inst%0d: acks=%b expected %b", inst, get_acks(inst), exp_ack);
      end
      exp_p = 8'(int'(ea[ch]) * int'(eb[ch]));
      checks++;
      if (get_prod(inst) !== exp_p) begin
        errors++;
        $display("FAIL prod inst%0d ch%0d: prod=%0d expected %0d", inst, ch, get_prod(inst), exp_p);
      end
      m_last[inst] = ch;
      set_req(inst, ch, 1'b0);
      tick();
      m_cnt[inst] = (m_cnt[inst] + 1) % 256;
      checks++;
      if (get_cnt(inst) !== 8'(m_cnt[inst])) begin
        errors++;
        $display("FAIL op_cnt inst%0d: op_cnt=%0d expected %0d", inst, get_cnt(inst), m_cnt[inst]);
      end
    end
  endtask

  task automatic test_reset();
    rst_0 = 1'b1; rst_1 = 1'b1;
    req0_0 = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({get_acks(i), get_busy(i)} !== 3'b000) begin
        errors++;
        $display("FAIL reset_ctrl inst%0d: acks/busy=%b expected 000", i, {get_acks(i), get_busy(i)});
      end
      checks++;
      if (get_prod(i) !== 8'd0) begin
        errors++;
        $display("FAIL reset_prod inst%0d: prod=%0d expected 0", i, get_prod(i));
      end
      checks++;
      if (get_cnt(i) !== 8'd0) begin
        errors++;
        $display("FAIL reset_cnt inst%0d: op_cnt=%0d expected 0", i, get_cnt(i));
      end
      m_last[i] = 0;
      m_cnt[i]  = 0;
    end
    req0_0 = 1'b0;
    rst_0 = 1'b0; rst_1 = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_ops(0, 0, 4'd9, 4'd1);
    set_req(0, 0, 1'b1);
    tick();
    checks++;
    if ({get_acks(0), get_busy(0)} !== 3'b001) begin
      errors++;
      $display("FAIL single_calc: acks/busy=%b expected 001", {get_acks(0), get_busy(0)});
    end
    tick();
    checks++;
    if (get_acks(0) !== 2'b01 || get_prod(0) !== 8'd9) begin
      errors++;
      $display("FAIL single_done: acks=%b prod=%0d expected 01 and 9", get_acks(0), get_prod(0));
    end
    set_req(0, 0, 1'b0);
    tick();
    checks++;
    if (get_cnt(0) !== 8'd1 || {get_acks(0), get_busy(0)} !== 3'b000) begin
      errors++;
      $display("FAIL single_release: op_cnt=%0d acks/busy=%b expected 1 and 000",
               get_cnt(0), {get_acks(0), get_busy(0)});
    end
    m_cnt[0]  = 1;
    m_last[0] = 0;
  endtask

  task automatic test_tie();
    serve_pattern(0, 3, 4'd10, 4'd5, 4'd12, 4'd5);
    serve_pattern(1, 3, 4'd10, 4'd5, 4'd12, 4'd5);
  endtask

  task automatic test_operand_change();
    serve_pattern(0, 2, 4'd0, 4'd0, 4'd15, 4'd15);
    tick();
    tick();
    tick();
    checks++;
    if (get_prod(0) !== 8'hE1) begin
      errors++;
      $display("FAIL prod_hold: prod=%0d expected 225", get_prod(0));
    end
  endtask

  task automatic test_hold();
    set_ops(0, 0, 4'd5, 4'd7);
    set_req(0, 0, 1'b1);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({get_acks(0), get_busy(0)} !== 3'b011) begin
        errors++;
        $display("FAIL hold_done cycle%0d: acks/busy=%b expected 011", i, {get_acks(0), get_busy(0)});
      end
    end
    checks++;
    if (get_prod(0) !== 8'd35) begin
      errors++;
      $display("FAIL hold_prod: prod=%0d expected 35", get_prod(0));
    end
    set_req(0, 0, 1'b0);
    tick();
    m_cnt[0]  = (m_cnt[0] + 1) % 256;
    m_last[0] = 0;
    checks++;
    if (get_cnt(0) !== 8'(m_cnt[0])) begin
      errors++;
      $display("FAIL hold_cnt: op_cnt=%0d expected %0d", get_cnt(0), m_cnt[0]);
    end
  endtask

  task automatic test_reset_abort();
    set_ops(0, 0, 4'd12, 4'd9);
    set_req(0, 0, 1'b1);
    tick();
    #2;
    rst_0 = 1'b1;
    #1;
    checks++;
    if ({get_acks(0), get_busy(0)} !== 3'b000 || get_prod(0) !== 8'd0 || get_cnt(0) !== 8'd0) begin
      errors++;
      $display("FAIL abort_async: acks/busy=%b prod=%0d op_cnt=%0d expected 000, 0, 0",
               {get_acks(0), get_busy(0)}, get_prod(0), get_cnt(0));
    end
    m_cnt[0]  = 0;
    m_last[0] = 0;
    tick();
    tick();
    checks++;
    if (get_busy(0) !== 1'b0) begin
      errors++;
      $display("FAIL abort_held: busy=%b expected 0", get_busy(0));
    end
    rst_0 = 1'b0;
    tick();
    tick();
    checks++;
    if (get_acks(0) !== 2'b01 || get_prod(0) !== 8'd108 || get_cnt(0) !== 8'd0) begin
      errors++;
      $display("FAIL abort_retry: acks=%b prod=%0d op_cnt=%0d expected 01, 108, 0",
               get_acks(0), get_prod(0), get_cnt(0));
    end
    set_req(0, 0, 1'b0);
    tick();
    m_cnt[0] = 1;
    checks++;
    if (get_cnt(0) !== 8'd1) begin
      errors++;
      $display("FAIL abort_cnt: op_cnt=%0d expected 1", get_cnt(0));
    end
  endtask

  task automatic test_back_to_back();
    int start;
    start = m_cnt[0];
    for (int i = 0; i < 256; i++)
      serve_pattern(0, int'($urandom_range(1, 2)), 4'($urandom), 4'($urandom),
                    4'($urandom), 4'($urandom));
    checks++;
    if (get_cnt(0) !== 8'(start)) begin
      errors++;
      $display("FAIL wrap: op_cnt=%0d expected %0d", get_cnt(0), start);
    end
  endtask

  task automatic test_random();
    for (int inst = 0; inst < 2; inst++) begin
      for (int i = 0; i < 60; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        serve_pattern(inst, int'($urandom_range(1, 3)), 4'($urandom), 4'($urandom),
                      4'($urandom), 4'($urandom));
      end
    end
  endtask

  initial begin
    rst_0 = 1'b1; rst_1 = 1'b1;
    req0_0 = 1'b0; req1_0 = 1'b0; req0_1 = 1'b0; req1_1 = 1'b0;
    a0_0 = '0; b0_0 = '0; a1_0 = '0; b1_0 = '0;
    a0_1 = '0; b0_1 = '0; a1_1 = '0; b1_1 = '0;
    test_reset();
    test_single();
    test_tie();
    test_operand_change();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
